// File: rtl/tone_pkg.sv
// Shared types for the keypad-to-tone-generator path.
// Note indices, key count and the octave state encoding live here.
package tone_pkg;

    localparam int NUM_KEYS = 12;

    typedef logic [3:0] note_t;

    typedef enum logic [1:0] {
        OCT_LOW  = 2'd0,
        OCT_MID  = 2'd1,
        OCT_HIGH = 2'd2
    } octave_t;

endpackage

// File: rtl/octave_sequencer.sv
// Octave button edge detect and the LOW -> MID -> HIGH -> LOW cycle.
// octave_shift is the registered state, used directly as a right-shift amount.
module octave_sequencer
    import tone_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       octave_btn,
    output logic [1:0] octave_shift
);

    octave_t state_q, state_d;
    logic    btn_q, btn_d;
    logic    rise;

    always_comb begin
        btn_d   = octave_btn;
        rise    = octave_btn & ~btn_q;
        state_d = state_q;
        case (state_q)
            OCT_LOW:  if (rise) state_d = OCT_MID;
            OCT_MID:  if (rise) state_d = OCT_HIGH;
            OCT_HIGH: if (rise) state_d = OCT_LOW;
            // Encoding 3 is never entered normally; fall back to LOW.
            default:  state_d = OCT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCT_LOW;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
        end
    end

    assign octave_shift = state_q;

endmodule

// File: rtl/voice_allocator.sv
// Scans the 12 keys one per clock and binds held keys to free tone voices.
// Also hosts the octave sequencer that sets the divider bank's shift.
module voice_allocator
    import tone_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_KEYS-1:0]     keys,
    input  logic                    octave_btn,
    output logic [4*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [1:0]              octave_shift,
    output logic                    voices_full
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [3:0]                scan_ptr_q, scan_ptr_d;
    logic [NUM_KEYS-1:0]       held_q, held_d;
    logic [VW-1:0]             owner_q [NUM_KEYS];
    logic [VW-1:0]             owner_d [NUM_KEYS];
    logic [NUM_VOICES-1:0]     voice_active_q, voice_active_d;
    note_t [NUM_VOICES-1:0]    voice_note_q, voice_note_d;
    logic                      voices_full_q, voices_full_d;

    logic [VW:0]               pick;
    logic                      free_found;
    logic [VW-1:0]             free_idx;

    // Returns {found, index} of the lowest-numbered inactive voice.
    function automatic logic [VW:0] pick_free(input logic [NUM_VOICES-1:0] active);
        logic [VW:0] result;
        result = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active[v]) begin
                result = {1'b1, VW'(v)};
            end
        end
        return result;
    endfunction

    always_comb begin
        scan_ptr_d     = (scan_ptr_q == 4'd11) ? 4'd0 : scan_ptr_q + 4'd1;
        held_d         = held_q;
        owner_d        = owner_q;
        voice_active_d = voice_active_q;
        voice_note_d   = voice_note_q;

        pick       = pick_free(voice_active_q);
        free_found = pick[VW];
        free_idx   = pick[VW-1:0];

        // A press without a free voice leaves held clear so the key is retried next scan.
        if (keys[scan_ptr_q] && !held_q[scan_ptr_q]) begin
            if (free_found) begin
                voice_active_d[free_idx] = 1'b1;
                voice_note_d[free_idx]   = scan_ptr_q;
                held_d[scan_ptr_q]       = 1'b1;
                owner_d[scan_ptr_q]      = free_idx;
            end
        end else if (!keys[scan_ptr_q] && held_q[scan_ptr_q]) begin
            voice_active_d[owner_q[scan_ptr_q]] = 1'b0;
            held_d[scan_ptr_q]                  = 1'b0;
        end

        voices_full_d = &voice_active_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_ptr_q     <= 4'd0;
            held_q         <= '0;
            voice_active_q <= '0;
            voice_note_q   <= '0;
            voices_full_q  <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            scan_ptr_q     <= scan_ptr_d;
            held_q         <= held_d;
            voice_active_q <= voice_active_d;
            voice_note_q   <= voice_note_d;
            voices_full_q  <= voices_full_d;
            owner_q        <= owner_d;
        end
    end

    octave_sequencer u_octave (
        .clk          (clk),
        .rst          (rst),
        .octave_btn   (octave_btn),
        .octave_shift (octave_shift)
    );

    assign voice_note   = voice_note_q;
    assign voice_active = voice_active_q;
    assign voices_full  = voices_full_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a queue of expected output values.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_voice_allocator;

    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [11:0]     keys = '0;
    logic            octave_btn = 1'b0;
    logic [4*NV-1:0] voice_note;
    logic [NV-1:0]   voice_active;
    logic [1:0]      octave_shift;
    logic            voices_full;

    int compare_count = 0;
    int fail_count    = 0;
    int oct_exp       = 0;
    int scan_pos      = 0;

    localparam int SEL_ACTIVE = 0;
    localparam int SEL_NOTES  = 1;
    localparam int SEL_FULL   = 2;
    localparam int SEL_OCT    = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk          (clk),
        .rst          (rst),
        .keys         (keys),
        .octave_btn   (octave_btn),
        .voice_note   (voice_note),
        .voice_active (voice_active),
        .octave_shift (octave_shift),
        .voices_full  (voices_full)
    );

    always #5 clk = ~clk;

    // Key that the scanner will visit on the next rising edge.
    always @(posedge clk) begin
        if (rst) scan_pos <= 0;
        else     scan_pos <= (scan_pos == 11) ? 0 : scan_pos + 1;
    end

    task automatic applyStimulus(input logic [11:0] k, input logic b, input logic r);
        keys       = k;
        octave_btn = b;
        rst        = r;
    endtask

    task automatic pushExp(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_ACTIVE: obs = {28'b0, voice_active};
                SEL_NOTES:  obs = {16'b0, voice_note};
                SEL_FULL:   obs = {31'b0, voices_full};
                default:    obs = {30'b0, octave_shift};
            endcase
            compare_count++;
            assert (obs === e.exp) else begin
                fail_count++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitScanPos(input int k);
        int tries;
        tries = 0;
        while (scan_pos != k && tries < 24) begin
            @(negedge clk);
            tries++;
        end
        if (scan_pos != k) begin
            compare_count++;
            fail_count++;
            $display("[TB] FAIL scan_wait observed=%0d expected=%0d", scan_pos, k);
        end
    endtask

    task automatic pulseOctave(input int hold);
        pushExp("oct_before_press", SEL_OCT, oct_exp);
        checkOutput();
        applyStimulus(keys, 1'b1, 1'b0);
        oct_exp = (oct_exp + 1) % 3;
        pushExp("oct_one_cycle", SEL_OCT, oct_exp);
        waitCycles(1);
        checkOutput();
        pushExp("oct_held", SEL_OCT, oct_exp);
        waitCycles(hold - 1);
        checkOutput();
        applyStimulus(keys, 1'b0, 1'b0);
        waitCycles(3);
    endtask

    initial begin
        waitCycles(2);
        pushExp("reset_active", SEL_ACTIVE, 0);
        pushExp("reset_notes",  SEL_NOTES,  0);
        pushExp("reset_full",   SEL_FULL,   0);
        pushExp("reset_oct",    SEL_OCT,    0);
        checkOutput();

        // Single key A.
        applyStimulus(12'h200, 1'b0, 1'b0);
        pushExp("a_active", SEL_ACTIVE, 32'h1);
        pushExp("a_notes",  SEL_NOTES,  32'h0009);
        pushExp("a_full",   SEL_FULL,   0);
        waitCycles(12);
        checkOutput();

        // Add C, then release A; voice 0 keeps its note.
        applyStimulus(12'h201, 1'b0, 1'b0);
        pushExp("ac_active", SEL_ACTIVE, 32'h3);
        pushExp("ac_notes",  SEL_NOTES,  32'h0009);
        waitCycles(12);
        checkOutput();
        applyStimulus(12'h001, 1'b0, 1'b0);
        pushExp("relA_active", SEL_ACTIVE, 32'h2);
        pushExp("relA_notes",  SEL_NOTES,  32'h0009);
        waitCycles(12);
        checkOutput();

        applyStimulus(12'h000, 1'b0, 1'b0);
        pushExp("all_off_active", SEL_ACTIVE, 0);
        waitCycles(12);
        checkOutput();

        // Five keys onto four voices.
        waitScanPos(0);
        applyStimulus(12'h0B5, 1'b0, 1'b0);
        pushExp("five_active", SEL_ACTIVE, 32'hF);
        pushExp("five_notes",  SEL_NOTES,  32'h5420);
        pushExp("five_full",   SEL_FULL,   1);
        waitCycles(12);
        checkOutput();
        applyStimulus(12'h0B1, 1'b0, 1'b0);
        pushExp("retry_active", SEL_ACTIVE, 32'hF);
        pushExp("retry_notes",  SEL_NOTES,  32'h5470);
        pushExp("retry_full",   SEL_FULL,   1);
        waitCycles(24);
        checkOutput();

        // Octave stepping: four short presses then one long hold.
        for (int i = 0; i < 4; i++) pulseOctave(3);
        pulseOctave(50);
        while (oct_exp != 1) pulseOctave(3);

        // Three voices in MID, then reset while keys stay high.
        applyStimulus(12'h000, 1'b0, 1'b0);
        waitCycles(12);
        waitScanPos(0);
        applyStimulus(12'h015, 1'b0, 1'b0);
        pushExp("three_active", SEL_ACTIVE, 32'h7);
        pushExp("three_notes",  SEL_NOTES,  32'h5420);
        pushExp("three_full",   SEL_FULL,   0);
        pushExp("three_oct",    SEL_OCT,    1);
        waitCycles(12);
        checkOutput();
        applyStimulus(12'h015, 1'b0, 1'b1);
        oct_exp = 0;
        pushExp("midrst_active", SEL_ACTIVE, 0);
        pushExp("midrst_notes",  SEL_NOTES,  0);
        pushExp("midrst_full",   SEL_FULL,   0);
        pushExp("midrst_oct",    SEL_OCT,    0);
        waitCycles(1);
        checkOutput();
        applyStimulus(12'h015, 1'b0, 1'b0);
        pushExp("realloc_active", SEL_ACTIVE, 32'h7);
        pushExp("realloc_notes",  SEL_NOTES,  32'h0420);
        waitCycles(12);
        checkOutput();

        // Fill all voices, then hand key 4's voice to key 5 on back-to-back visits.
        applyStimulus(12'h215, 1'b0, 1'b0);
        pushExp("fill_active", SEL_ACTIVE, 32'hF);
        pushExp("fill_notes",  SEL_NOTES,  32'h9420);
        pushExp("fill_full",   SEL_FULL,   1);
        waitCycles(12);
        checkOutput();
        waitScanPos(4);
        applyStimulus(12'h225, 1'b0, 1'b0);
        pushExp("handoff_rel_active", SEL_ACTIVE, 32'hB);
        pushExp("handoff_rel_full",   SEL_FULL,   0);
        waitCycles(1);
        checkOutput();
        pushExp("handoff_new_active", SEL_ACTIVE, 32'hF);
        pushExp("handoff_new_notes",  SEL_NOTES,  32'h9520);
        pushExp("handoff_new_full",   SEL_FULL,   1);
        waitCycles(1);
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
